// File: rtl/align_shifter.sv
// Mantissa alignment unit: right-shifts the smaller-exponent operand one bit per cycle.
// Optional macro ALIGN_STICKY_EN folds shifted-out bits into a sticky LSB.
module align_shifter #(
  parameter int unsigned MAX_SHIFT = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [8:0]  dif,
  input  logic [31:0] big,
  input  logic [31:0] little,
  output logic        busy,
  output logic        done,
  output logic [7:0]  exp_out,
  output logic        sign_big,
  output logic        sign_little,
  output logic [23:0] mant_big,
  output logic [26:0] mant_little
);

  localparam int CW = $clog2(MAX_SHIFT + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [7:0]     exp_q, exp_d;
  logic           sign_big_q, sign_big_d;
  logic           sign_little_q, sign_little_d;
  logic [23:0]    mant_big_q, mant_big_d;
  logic [26:0]    mant_little_q, mant_little_d;

  logic           accept;
  logic [CW-1:0]  n_load;
  logic [26:0]    shifted;

  // Saturate the requested shift so large differences cannot wrap the counter.
  always_comb begin
    n_load = dif[CW-1:0];
    if (dif > 9'(MAX_SHIFT))
      n_load = CW'(MAX_SHIFT);
  end

  always_comb begin
`ifdef ALIGN_STICKY_EN
    shifted = {1'b0, mant_little_q[26:2], mant_little_q[1] | mant_little_q[0]};
`else
    shifted = {1'b0, mant_little_q[26:1]};
`endif
  end

  assign accept = start && (state_q != SHIFT);

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    exp_d         = exp_q;
    sign_big_d    = sign_big_q;
    sign_little_d = sign_little_q;
    mant_big_d    = mant_big_q;
    mant_little_d = mant_little_q;

    if (accept) begin
      exp_d         = big[30:23];
      sign_big_d    = big[31];
      sign_little_d = little[31];
      mant_big_d    = {|big[30:23], big[22:0]};
      mant_little_d = {|little[30:23], little[22:0], 3'b000};
      count_d       = n_load;
      state_d       = (n_load == '0) ? DONE : SHIFT;
    end else begin
      case (state_q)
        SHIFT: begin
          mant_little_d = shifted;
          count_d       = count_q - CW'(1);
          if (count_q == CW'(1))
            state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      count_q       <= '0;
      exp_q         <= '0;
      sign_big_q    <= 1'b0;
      sign_little_q <= 1'b0;
      mant_big_q    <= '0;
      mant_little_q <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      exp_q         <= exp_d;
      sign_big_q    <= sign_big_d;
      sign_little_q <= sign_little_d;
      mant_big_q    <= mant_big_d;
      mant_little_q <= mant_little_d;
    end
  end

  assign busy        = (state_q == SHIFT);
  assign done        = (state_q == DONE);
  assign exp_out     = exp_q;
  assign sign_big    = sign_big_q;
  assign sign_little = sign_little_q;
  assign mant_big    = mant_big_q;
  assign mant_little = mant_little_q;

endmodule

// File: tb/tb_align_shifter.sv
// Directed bench for align_shifter with an expected-result queue and immediate-assertion checks.
module tb_align_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  dif;
  logic [31:0] big, little;
  logic        busy, done, sign_big, sign_little;
  logic [7:0]  exp_out;
  logic [23:0] mant_big;
  logic [26:0] mant_little;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  e;
    logic        sb;
    logic        sl;
    logic [23:0] mb;
    logic [26:0] ml;
    int          n;
  } exp_t;

  exp_t sb_q[$];

  align_shifter #(.MAX_SHIFT(27)) dut (
    .clk(clk), .rst(rst), .start(start), .dif(dif), .big(big), .little(little),
    .busy(busy), .done(done), .exp_out(exp_out), .sign_big(sign_big),
    .sign_little(sign_little), .mant_big(mant_big), .mant_little(mant_little)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [31:0] b, input logic [31:0] l, input int d);
    exp_t r;
    logic [26:0] m;
    r.n  = (d > 27) ? 27 : d;
    r.e  = b[30:23];
    r.sb = b[31];
    r.sl = l[31];
    r.mb = {(b[30:23] != 8'h00), b[22:0]};
    m    = {(l[30:23] != 8'h00), l[22:0], 3'b000};
    for (int i = 0; i < r.n; i++) begin
`ifdef ALIGN_STICKY_EN
      m = {1'b0, m[26:2], m[1] | m[0]};
`else
      m = m >> 1;
`endif
    end
    r.ml = m;
    return r;
  endfunction

  task automatic check_outs(input exp_t x, input string tag);
    chk(32'(exp_out), 32'(x.e), {tag, "_exp"});
    chk(32'(sign_big), 32'(x.sb), {tag, "_sb"});
    chk(32'(sign_little), 32'(x.sl), {tag, "_sl"});
    chk(32'(mant_big), 32'(x.mb), {tag, "_mb"});
    chk(32'(mant_little), 32'(x.ml), {tag, "_ml"});
  endtask

  task automatic check_zero(input string tag);
    chk({busy, done, sign_big, sign_little}, 32'h0, {tag, "_ctl"});
    chk(32'(exp_out), 32'h0, {tag, "_exp"});
    chk(32'(mant_big), 32'h0, {tag, "_mb"});
    chk(32'(mant_little), 32'h0, {tag, "_ml"});
  endtask

  // Drive start before an edge; returns #1 after the accepting edge (edge 0).
  task automatic issue(input logic [31:0] b, input logic [31:0] l, input int d, input bit push);
    @(negedge clk);
    start = 1'b1; big = b; little = l; dif = 9'(d);
    if (push) sb_q.push_back(model(b, l, d));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called #1 after edge cyc0; waits for done, checks latency and results.
  task automatic wait_done(input int cyc0, input string tag, input bit hold_chk);
    int cyc = cyc0;
    exp_t x;
    while (done !== 1'b1 && cyc < 120) begin
      chk(32'(busy), 32'h1, {tag, "_busy"});
      @(posedge clk); #1;
      cyc++;
    end
    if (done !== 1'b1) begin
      chk(32'(done), 32'h1, {tag, "_timeout"});
      return;
    end
    if (sb_q.size() == 0) begin
      chk(32'h0, 32'h1, {tag, "_unexpected_done"});
      return;
    end
    x = sb_q.pop_front();
    chk(32'(cyc), 32'(x.n), {tag, "_latency"});
    chk(32'(busy), 32'h0, {tag, "_busy_at_done"});
    check_outs(x, tag);
    if (hold_chk) begin
      @(posedge clk); #1;
      chk(32'(done), 32'h0, {tag, "_done_1cyc"});
      @(posedge clk); #1;
      chk(32'(busy), 32'h0, {tag, "_idle_busy"});
      check_outs(x, {tag, "_hold"});
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dif = '0; big = '0; little = '0;
    #1;
    check_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // Equal exponents: no shifting.
    issue(32'h3F800000, 32'h3F800000, 0, 1'b1);
    wait_done(0, "dif0", 1'b1);
    chk(32'(mant_little), 32'h4000000, "dif0_lit_ml");
    chk(32'(mant_big), 32'h800000, "dif0_lit_mb");

    issue(32'h3F800000, 32'h3F000000, 1, 1'b1);
    wait_done(0, "dif1", 1'b1);
    chk(32'(mant_little), 32'h2000000, "dif1_lit_ml");

    // Saturated shift with a low set bit that must be lost or kept sticky.
    issue(32'h7F000000, 32'h3F800001, 200, 1'b1);
    wait_done(0, "sat200", 1'b1);
`ifdef ALIGN_STICKY_EN
    chk(32'(mant_little), 32'h1, "sat200_lit_ml");
`else
    chk(32'(mant_little), 32'h0, "sat200_lit_ml");
`endif

    issue(32'h00800000, 32'h00000001, 1, 1'b1);
    wait_done(0, "denorm", 1'b1);
    chk(32'(mant_little), 32'h4, "denorm_lit_ml");
    chk(32'(exp_out), 32'h01, "denorm_lit_exp");

    // Signs and a mid-range shift, then exact saturation boundary values.
    issue(32'hC1234567, 32'hBF9ABCDE, 5, 1'b1);
    wait_done(0, "sign5", 1'b1);
    issue(32'h4B7FFFFF, 32'h407FFFFF, 27, 1'b1);
    wait_done(0, "dif27", 1'b1);
    issue(32'h4B7FFFFF, 32'h407FFFFF, 28, 1'b1);
    wait_done(0, "dif28", 1'b1);
    issue(32'h4B7FFFFF, 32'h407FFFFF, 26, 1'b1);
    wait_done(0, "dif26", 1'b1);
    issue(32'h4B7FFFFF, 32'h407FFFFF, 511, 1'b1);
    wait_done(0, "dif511", 1'b1);

    // Start during SHIFT is ignored.
    issue(32'h41200000, 32'h3FC00003, 10, 1'b1);
    repeat (2) begin
      @(posedge clk); #1;
      chk(32'(busy), 32'h1, "ign_busy");
    end
    issue(32'h12345678, 32'h0ABCDEF0, 1, 1'b0);
    wait_done(3, "ignore", 1'b1);

    // Start accepted in DONE: back-to-back operations.
    issue(32'h40000000, 32'h3F7FFFFF, 2, 1'b1);
    wait_done(0, "b2b_a", 1'b0);
    issue(32'hC0400000, 32'h3E800007, 3, 1'b1);
    wait_done(0, "b2b_b", 1'b1);
    issue(32'h40000000, 32'h3F7FFFFF, 2, 1'b1);
    wait_done(0, "b2b_c", 1'b0);
    issue(32'h40000000, 32'h3F000000, 0, 1'b1);
    wait_done(0, "b2b_d", 1'b1);

    // Reset mid-SHIFT aborts everything immediately.
    issue(32'h42000000, 32'h3F800005, 20, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk(32'(busy), 32'h1, "rst_pre_busy");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("rst_mid");
    void'(sb_q.pop_front());
    start = 1'b1; big = 32'h3F800000; little = 32'h3F800000; dif = 9'd0;
    @(posedge clk); #1;
    check_zero("rst_start");
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      chk({30'h0, busy, done}, 32'h0, "rst_no_done");
    end
    issue(32'h3F800000, 32'h3F800000, 0, 1'b1);
    wait_done(0, "post_rst", 1'b1);
    chk(32'(sb_q.size()), 32'h0, "queue_empty");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/align_shifter.md
ALIGN_SHIFTER -- requirements
Module: align_shifter

Interface
REQ-001: Parameter MAX_SHIFT, default 27, saturation limit on the effective shift count.
REQ-002: clk  input  1  single clock; all state changes on rising edge.
REQ-003: rst  input  1  reset, asynchronous, active-high.
REQ-004: start  input  1  one-cycle request to align a new operand pair.
REQ-005: dif  input  9  unsigned exponent difference, always >= 0.
REQ-006: big  input  32  IEEE-754 single operand with the larger exponent.
REQ-007: little  input  32  IEEE-754 single operand with the smaller exponent.
REQ-008: busy  output  1  high while an operation is in progress (SHIFT state).
REQ-009: done  output  1  high for exactly one cycle when results are valid.
REQ-010: exp_out  output  8  latched exponent field of big.
REQ-011: sign_big, sign_little  output  1 each  latched sign bits.
REQ-012: mant_big  output  24  {hidden, big[22:0]}.
REQ-013: mant_little  output  27  {hidden, fraction, G, R, S} of little after alignment.

Function
REQ-014: Hidden bit SHALL be 1 when exponent field != 0, else 0 (denormal/zero).
REQ-015: States SHALL be IDLE, SHIFT, DONE; encoding free.
REQ-016: start SHALL be accepted in IDLE or DONE; start SHALL be ignored in SHIFT.
REQ-017: On an accepted start, block SHALL latch exp_out, signs, mant_big, and mant_little = {hidden, little[22:0], 3'b000}, and load count N = min(dif, MAX_SHIFT).
REQ-018: Accepted start with N = 0 SHALL go to DONE; N > 0 SHALL go to SHIFT.
REQ-019: Each SHIFT cycle SHALL shift mant_little right by exactly one bit and decrement count; on the edge where count reaches 0, state SHALL become DONE.
REQ-020: Latency: counting the accepting edge as edge 0, done SHALL be high in the cycle after edge N (N = 0: cycle immediately after start).
REQ-021: DONE SHALL last one cycle, then IDLE unless a new start is accepted in DONE.
REQ-022: Outputs SHALL hold their values after DONE until the next accepted start.
REQ-023: busy SHALL equal (state == SHIFT); done SHALL equal (state == DONE).
REQ-024: dif values above MAX_SHIFT (up to 511) SHALL saturate; no wrap of count.
REQ-025: start coinciding with rst SHALL be ignored.

Reset
REQ-026: rst high SHALL immediately force state IDLE, count 0, and all outputs (busy, done, exp_out, signs, mant_big, mant_little) to 0, including mid-SHIFT.
REQ-027: First start after rst deassertion SHALL be accepted normally.

Configuration
REQ-028: Macro ALIGN_STICKY_EN defined: each shift SHALL compute new = {0, old[26:2], old[1] | old[0]} (bit 0 sticky).
REQ-029: Macro ALIGN_STICKY_EN undefined: each shift SHALL compute new = {0, old[26:1]}; bits shifted past bit 0 are lost.

Verification
REQ-030: big=0x3F800000, little=0x3F800000, dif=0, start -> done next cycle, mant_big=0x800000, mant_little=27'h4000000, exp_out=0x7F, busy never high.
REQ-031: big=0x3F800000, little=0x3F000000, dif=1 -> busy 1 cycle, done after edge 1, mant_little=27'h2000000.
REQ-032: big=0x7F000000, little=0x3F800001, dif=200 -> 27 SHIFT cycles, done after edge 27; mant_little=27'h0000001 with ALIGN_STICKY_EN, 27'h0000000 without.
REQ-033: big=0x00800000, little=0x00000001 (denormal), dif=1 -> initial mant_little 27'h0000008, result 27'h0000004, exp_out=0x01.
REQ-034: dif=10 start, second start with different operands at edge 3 -> second ignored, results match first operands, done after edge 10.
REQ-035: dif=20 start, rst pulse at edge 5 -> all outputs 0 immediately, no done; subsequent dif=0 start completes normally.
